// File: rtl/spc_link_responder.sv
// Responder/observer for the spc single-wire pulse-width link: decodes bytes from
// low-pulse widths and answers read slots by holding the open-drain line low for 0-bits.
module spc_link_responder #(
    parameter int CNT_W        = 12,
    parameter int T_GLITCH     = 4,
    parameter int T_BIT_THRESH = 60,
    parameter int T_HOLD       = 120,
    parameter int T_RESET      = 600,
    parameter int T_IDLE       = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       line_in,
    output logic       line_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_rst,
    output logic       err
);

    if (!(T_GLITCH < T_BIT_THRESH && T_BIT_THRESH < T_HOLD && T_HOLD < T_RESET &&
          T_RESET < (2 ** CNT_W) - 1 && T_IDLE < (2 ** CNT_W))) begin : g_param_check
        $error("spc_link_responder: timing parameters out of order or too wide for CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(T_GLITCH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(T_BIT_THRESH);
    localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(T_RESET);
    localparam logic [CNT_W-1:0] IDLE_C   = CNT_W'(T_IDLE);

    logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d, high_cnt_q, high_cnt_d, hold_q, hold_d;
    logic [7:0]       rx_sr_q, rx_sr_d, rx_data_q, rx_data_d, tx_byte_q, tx_byte_d;
    logic [2:0]       rx_idx_q, rx_idx_d, tx_idx_q, tx_idx_d;
    logic             rx_valid_q, rx_valid_d, frame_rst_q, frame_rst_d, err_q, err_d;
    logic             tx_busy_q, tx_busy_d, line_oe_q, line_oe_d;
    logic             line_s, fall_s, rise_s, is_frst_s, is_bit_s, bit_val_s, timeout_s, abort_s;

    // Edge detection, duration counting, slot decode and transmit control.
    always_comb begin
        line_s    = sync2_q;
        fall_s    = prev_q & ~line_s;
        rise_s    = ~prev_q & line_s;
        sync1_d   = line_in;
        sync2_d   = sync1_q;
        prev_d    = line_s;

        // Counts include the edge cycle, so at a rise low_cnt equals the low width in clocks.
        if (fall_s) begin
            low_cnt_d = ONE_C;
        end else if (!line_s && low_cnt_q != CNT_MAX) begin
            low_cnt_d = low_cnt_q + ONE_C;
        end else begin
            low_cnt_d = low_cnt_q;
        end
        if (rise_s) begin
            high_cnt_d = ONE_C;
        end else if (line_s && high_cnt_q != CNT_MAX) begin
            high_cnt_d = high_cnt_q + ONE_C;
        end else begin
            high_cnt_d = high_cnt_q;
        end

        is_frst_s = rise_s && (low_cnt_q >= RESET_C);
        is_bit_s  = rise_s && (low_cnt_q >= GLITCH_C) && (low_cnt_q < RESET_C);
        bit_val_s = (low_cnt_q < THRESH_C);
        // prev_q excludes the rise cycle, where high_cnt still holds the previous phase.
        timeout_s = prev_q && line_s && (high_cnt_q == IDLE_C) && (rx_idx_q != 3'd0);
        abort_s   = is_frst_s || timeout_s;

        rx_sr_d     = rx_sr_q;
        rx_idx_d    = rx_idx_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_rst_d = 1'b0;
        err_d       = 1'b0;
        if (is_frst_s) begin
            frame_rst_d = 1'b1;
            rx_idx_d    = 3'd0;
            rx_sr_d     = 8'h00;
        end else if (is_bit_s) begin
            rx_sr_d = {rx_sr_q[6:0], bit_val_s};
            if (rx_idx_q == 3'd7) begin
                rx_data_d  = {rx_sr_q[6:0], bit_val_s};
                rx_valid_d = 1'b1;
                rx_idx_d   = 3'd0;
            end else begin
                rx_idx_d = rx_idx_q + 3'd1;
            end
        end else if (timeout_s) begin
            err_d    = 1'b1;
            rx_idx_d = 3'd0;
            rx_sr_d  = 8'h00;
        end else begin
            rx_sr_d = rx_sr_q;
        end

        tx_byte_d = tx_byte_q;
        tx_idx_d  = tx_idx_q;
        tx_busy_d = tx_busy_q;
        line_oe_d = line_oe_q;
        hold_d    = hold_q;
        if (abort_s) begin
            tx_busy_d = 1'b0;
            line_oe_d = 1'b0;
            hold_d    = '0;
        end else begin
            if (line_oe_q) begin
                if (hold_q == '0) begin
                    line_oe_d = 1'b0;
                end else begin
                    hold_d = hold_q - ONE_C;
                end
            end else if (fall_s && tx_busy_q && !tx_byte_q[tx_idx_q]) begin
                line_oe_d = 1'b1;
                hold_d    = HOLD_C - ONE_C;
            end else begin
                line_oe_d = 1'b0;
            end
            if (is_bit_s && tx_busy_q) begin
                if (tx_idx_q == 3'd0) begin
                    tx_busy_d = 1'b0;
                end else begin
                    tx_idx_d = tx_idx_q - 3'd1;
                end
            end else begin
                tx_idx_d = tx_idx_q;
            end
        end
        // An abort in the same cycle frees the transmitter, so the load is taken afterwards.
        if (tx_load && (!tx_busy_q || abort_s)) begin
            tx_byte_d = tx_data;
            tx_busy_d = 1'b1;
            tx_idx_d  = 3'd7;
        end else begin
            tx_byte_d = tx_byte_d;
        end
    end

    // State registers; the line idles high, so synchronizer and last sample reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            low_cnt_q   <= '0;
            high_cnt_q  <= '0;
            hold_q      <= '0;
            rx_sr_q     <= 8'h00;
            rx_idx_q    <= 3'd0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_rst_q <= 1'b0;
            err_q       <= 1'b0;
            tx_byte_q   <= 8'h00;
            tx_idx_q    <= 3'd0;
            tx_busy_q   <= 1'b0;
            line_oe_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            low_cnt_q   <= low_cnt_d;
            high_cnt_q  <= high_cnt_d;
            hold_q      <= hold_d;
            rx_sr_q     <= rx_sr_d;
            rx_idx_q    <= rx_idx_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_rst_q <= frame_rst_d;
            err_q       <= err_d;
            tx_byte_q   <= tx_byte_d;
            tx_idx_q    <= tx_idx_d;
            tx_busy_q   <= tx_busy_d;
            line_oe_q   <= line_oe_d;
        end
    end

    assign line_oe   = line_oe_q;
    assign tx_busy   = tx_busy_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_rst = frame_rst_q;
    assign err       = err_q;

endmodule
